// File: rtl/asrv32_clint_ctrl_if.sv
// ---------------------------------------------------------------------------
// asrv32_clint_ctrl_if
// Wishbone-style 32-bit bus bundle between the data-bus master and the CLINT
// controller.
//   i_wb_cyc / i_wb_stb : bus cycle active / request strobe (master -> slave)
//   i_wb_we             : 1 = write, 0 = read
//   i_wb_addr           : byte offset within the CLINT window, [1:0] ignored
//   i_wb_data / i_wb_sel: write data and byte enables
//   o_wb_ack            : one-cycle completion pulse (slave -> master)
//   o_wb_stall          : request not accepted this cycle
//   o_wb_data           : read data, valid with o_wb_ack
// Signal names keep the slave-side i_/o_ prefixes so both ends read the same.
// ---------------------------------------------------------------------------
interface asrv32_clint_ctrl_if #(
  parameter int ADDR_W = 5
) ();
  logic              i_wb_cyc;
  logic              i_wb_stb;
  logic              i_wb_we;
  logic [ADDR_W-1:0] i_wb_addr;
  logic [31:0]       i_wb_data;
  logic [3:0]        i_wb_sel;
  logic              o_wb_ack;
  logic              o_wb_stall;
  logic [31:0]       o_wb_data;

  modport master (
    output i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_data, i_wb_sel,
    input  o_wb_ack, o_wb_stall, o_wb_data
  );

  modport slave (
    input  i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_data, i_wb_sel,
    output o_wb_ack, o_wb_stall, o_wb_data
  );
endinterface

// File: rtl/asrv32_clint_ctrl.sv
// ---------------------------------------------------------------------------
// asrv32_clint_ctrl
// Memory-mapped machine-timer / software-interrupt controller. Turns 32-bit
// bus accesses into the CSR unit's 64-bit mtime/mtimecmp write strobes and
// drives the software-interrupt input. After reset it pushes MTIMECMP_RST to
// the CSR once so no spurious timer interrupt can fire.
//
// Ports:
//   i_clk, i_rst_n          : clock, asynchronous active-low reset
//   wb (slave modport)      : Wishbone-style 32-bit bus, see asrv32_clint_ctrl_if
//   i_mtime                 : live mtime from the CSR unit
//   o_mtime_wr_en/_din      : one-cycle mtime write strobe and 64-bit data
//   o_mtimecmp_wr_en/_din   : one-cycle mtimecmp write strobe, din = shadow
//   o_software_interrupt    : msip[0]
//
// Register map (word offsets): 0x00 MSIP, 0x04 MTIMECMP_LO, 0x08 MTIMECMP_HI,
// 0x0C MTIME_LO, 0x10 MTIME_HI; anything else reads 0 and ignores writes.
//
// Optional feature macro: ASRV32_CLINT_ATOMIC_CMP_EN
//   When defined, a MTIMECMP_LO write only updates the shadow and marks the
//   low half pending; the following MTIMECMP_HI write commits both halves
//   with a single strobe.
// ---------------------------------------------------------------------------
module asrv32_clint_ctrl #(
  parameter logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF,
  parameter int          ADDR_W       = 5
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  asrv32_clint_ctrl_if.slave         wb,
  input  logic [63:0]                i_mtime,
  output logic                       o_mtime_wr_en,
  output logic [63:0]                o_mtime_din,
  output logic                       o_mtimecmp_wr_en,
  output logic [63:0]                o_mtimecmp_din,
  output logic                       o_software_interrupt
);

  localparam int WORD_W = ADDR_W - 2;

  typedef enum logic [1:0] {
    S_INIT = 2'd0,
    S_IDLE = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic        ack_q,       ack_d;
  logic [31:0] rdata_q,     rdata_d;
  logic        mtime_wr_q,  mtime_wr_d;
  logic [63:0] mtime_din_q, mtime_din_d;
  logic        cmp_wr_q,    cmp_wr_d;
  logic [63:0] shadow_q,    shadow_d;
  logic        msip_q,      msip_d;
  logic [31:0] hi_snap_q,   hi_snap_d;
`ifdef ASRV32_CLINT_ATOMIC_CMP_EN
  logic        lo_pending_q, lo_pending_d;
`endif

  logic              accept;
  logic              stall;
  logic              init_pulse;
  logic [WORD_W-1:0] word_idx;
  logic              is_msip, is_cmp_lo, is_cmp_hi, is_mt_lo, is_mt_hi;
  logic              unused_addr_bits;

  // Per-byte write merge: selected bytes take the bus data.
  function automatic logic [31:0] merge_bytes(input logic [31:0] cur,
                                              input logic [31:0] wdat,
                                              input logic [3:0]  sel);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[8*b +: 8] = sel[b] ? wdat[8*b +: 8] : cur[8*b +: 8];
    end
    return res;
  endfunction

  // Byte-lane bits of the address carry no information for word registers.
  assign unused_addr_bits = ^wb.i_wb_addr[1:0];

  assign word_idx  = wb.i_wb_addr[ADDR_W-1:2];
  assign is_msip   = (word_idx == WORD_W'(0));
  assign is_cmp_lo = (word_idx == WORD_W'(1));
  assign is_cmp_hi = (word_idx == WORD_W'(2));
  assign is_mt_lo  = (word_idx == WORD_W'(3));
  assign is_mt_hi  = (word_idx == WORD_W'(4));

  assign accept = (state_q == S_IDLE) && wb.i_wb_cyc && wb.i_wb_stb;

  // FSM: state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= S_INIT;
    else          state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_INIT:  state_d = S_IDLE;
      S_IDLE:  if (accept) state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_INIT;
    endcase
  end

  // FSM: outputs. The INIT strobe is gated by reset so both write strobes
  // stay low while reset is held and fire only in the first cycle after it.
  always_comb begin
    stall      = 1'b1;
    init_pulse = 1'b0;
    case (state_q)
      S_INIT:  init_pulse = i_rst_n;
      S_IDLE:  stall      = 1'b0;
      default: stall      = 1'b1;
    endcase
  end

  // Datapath next-state: all effects of a request are registered at
  // acceptance so they appear together with the ack in RESP.
  always_comb begin
    ack_d       = 1'b0;
    rdata_d     = rdata_q;
    mtime_wr_d  = 1'b0;
    mtime_din_d = mtime_din_q;
    cmp_wr_d    = 1'b0;
    shadow_d    = shadow_q;
    msip_d      = msip_q;
    hi_snap_d   = hi_snap_q;
`ifdef ASRV32_CLINT_ATOMIC_CMP_EN
    lo_pending_d = lo_pending_q;
`endif
    if (accept) begin
      ack_d   = 1'b1;
      rdata_d = '0;
      if (wb.i_wb_we) begin
        if (is_msip) begin
          if (wb.i_wb_sel[0]) msip_d = wb.i_wb_data[0];
        end else if (is_cmp_lo) begin
          shadow_d[31:0] = merge_bytes(shadow_q[31:0], wb.i_wb_data, wb.i_wb_sel);
`ifdef ASRV32_CLINT_ATOMIC_CMP_EN
          lo_pending_d = 1'b1;
`else
          cmp_wr_d = 1'b1;
`endif
        end else if (is_cmp_hi) begin
          shadow_d[63:32] = merge_bytes(shadow_q[63:32], wb.i_wb_data, wb.i_wb_sel);
          cmp_wr_d        = 1'b1;
`ifdef ASRV32_CLINT_ATOMIC_CMP_EN
          lo_pending_d = 1'b0;
`endif
        end else if (is_mt_lo) begin
          // Untouched half is the live mtime; no carry is propagated.
          mtime_din_d = {i_mtime[63:32],
                         merge_bytes(i_mtime[31:0], wb.i_wb_data, wb.i_wb_sel)};
          mtime_wr_d  = 1'b1;
        end else if (is_mt_hi) begin
          mtime_din_d = {merge_bytes(i_mtime[63:32], wb.i_wb_data, wb.i_wb_sel),
                         i_mtime[31:0]};
          mtime_wr_d  = 1'b1;
        end
      end else begin
        if (is_msip) begin
          rdata_d = {31'd0, msip_q};
        end else if (is_cmp_lo) begin
          rdata_d = shadow_q[31:0];
        end else if (is_cmp_hi) begin
          rdata_d = shadow_q[63:32];
        end else if (is_mt_lo) begin
          // Freeze the high half so a following HI read pairs with this LO.
          rdata_d   = i_mtime[31:0];
          hi_snap_d = i_mtime[63:32];
        end else if (is_mt_hi) begin
          rdata_d = hi_snap_q;
        end
      end
    end
  end

  // Datapath registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ack_q       <= 1'b0;
      rdata_q     <= '0;
      mtime_wr_q  <= 1'b0;
      mtime_din_q <= '0;
      cmp_wr_q    <= 1'b0;
      shadow_q    <= MTIMECMP_RST;
      msip_q      <= 1'b0;
      hi_snap_q   <= '0;
    end else begin
      ack_q       <= ack_d;
      rdata_q     <= rdata_d;
      mtime_wr_q  <= mtime_wr_d;
      mtime_din_q <= mtime_din_d;
      cmp_wr_q    <= cmp_wr_d;
      shadow_q    <= shadow_d;
      msip_q      <= msip_d;
      hi_snap_q   <= hi_snap_d;
    end
  end

`ifdef ASRV32_CLINT_ATOMIC_CMP_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) lo_pending_q <= 1'b0;
    else          lo_pending_q <= lo_pending_d;
  end
`endif

  assign wb.o_wb_ack           = ack_q;
  assign wb.o_wb_stall         = stall;
  assign wb.o_wb_data          = rdata_q;
  assign o_mtime_wr_en         = mtime_wr_q;
  assign o_mtime_din           = mtime_din_q;
  assign o_mtimecmp_wr_en      = cmp_wr_q | init_pulse;
  assign o_mtimecmp_din        = shadow_q;
  assign o_software_interrupt  = msip_q;

endmodule

// File: tb/tb_asrv32_clint_ctrl.sv
// ---------------------------------------------------------------------------
// tb_asrv32_clint_ctrl
// Directed bench for the CLINT controller: reset/INIT strobe, MSIP, mtime
// snapshot reads, mtime and mtimecmp write strobes, unmapped addresses,
// back-to-back throughput and reset during the response cycle.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_asrv32_clint_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] mtime;
  logic        mtime_wr_en;
  logic [63:0] mtime_din;
  logic        cmp_wr_en;
  logic [63:0] cmp_din;
  logic        sw_int;

  int checks   = 0;
  int failures = 0;

  asrv32_clint_ctrl_if bus ();

  asrv32_clint_ctrl dut (
    .i_clk                (clk),
    .i_rst_n              (rst_n),
    .wb                   (bus),
    .i_mtime              (mtime),
    .o_mtime_wr_en        (mtime_wr_en),
    .o_mtime_din          (mtime_din),
    .o_mtimecmp_wr_en     (cmp_wr_en),
    .o_mtimecmp_din       (cmp_din),
    .o_software_interrupt (sw_int)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic bus_idle();
    bus.i_wb_cyc  = 1'b0;
    bus.i_wb_stb  = 1'b0;
    bus.i_wb_we   = 1'b0;
    bus.i_wb_addr = '0;
    bus.i_wb_data = '0;
    bus.i_wb_sel  = '0;
  endtask

  // Issue one request from a negedge, wait out any stall, drop cyc/stb right
  // after acceptance and return at the negedge of the response cycle.
  task automatic bus_xfer(input logic we, input logic [4:0] addr,
                          input logic [31:0] data, input logic [3:0] sel);
    int n;
    @(negedge clk);
    bus.i_wb_cyc  = 1'b1;
    bus.i_wb_stb  = 1'b1;
    bus.i_wb_we   = we;
    bus.i_wb_addr = addr;
    bus.i_wb_data = data;
    bus.i_wb_sel  = sel;
    n = 0;
    while (bus.o_wb_stall && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk("stall_timeout", {63'd0, bus.o_wb_stall}, 64'd0);
    @(posedge clk);
    #1;
    bus_idle();
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    mtime = '0;
    bus_idle();

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_ack",      {63'd0, bus.o_wb_ack}, 64'd0);
    chk("rst_rdata",    {32'd0, bus.o_wb_data}, 64'd0);
    chk("rst_mt_wr",    {63'd0, mtime_wr_en}, 64'd0);
    chk("rst_cmp_wr",   {63'd0, cmp_wr_en}, 64'd0);
    chk("rst_mt_din",   mtime_din, 64'd0);
    chk("rst_cmp_din",  cmp_din, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("rst_swi",      {63'd0, sw_int}, 64'd0);

    // INIT cycle after release
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("init_cmp_wr",  {63'd0, cmp_wr_en}, 64'd1);
    chk("init_cmp_din", cmp_din, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("init_stall",   {63'd0, bus.o_wb_stall}, 64'd1);
    chk("init_ack",     {63'd0, bus.o_wb_ack}, 64'd0);
    @(negedge clk);
    chk("idle_cmp_wr",  {63'd0, cmp_wr_en}, 64'd0);
    chk("idle_stall",   {63'd0, bus.o_wb_stall}, 64'd0);

    // MSIP
    bus_xfer(1'b1, 5'h00, 32'h1, 4'b0001);
    chk("msip_wr_ack",  {63'd0, bus.o_wb_ack}, 64'd1);
    chk("msip_wr_swi",  {63'd0, sw_int}, 64'd1);
    chk("msip_no_mtwr", {63'd0, mtime_wr_en}, 64'd0);
    chk("msip_no_cmpwr",{63'd0, cmp_wr_en}, 64'd0);
    bus_xfer(1'b0, 5'h00, 32'h0, 4'b1111);
    chk("msip_rd",      {32'd0, bus.o_wb_data}, 64'd1);
    bus_xfer(1'b1, 5'h00, 32'h0, 4'b0001);
    chk("msip_clr",     {63'd0, sw_int}, 64'd0);
    bus_xfer(1'b1, 5'h00, 32'hFFFF_FFFF, 4'b1110);
    chk("msip_nosel",   {63'd0, sw_int}, 64'd0);

    // mtime snapshot read pair
    mtime = 64'h0000_0005_FFFF_FFF0;
    bus_xfer(1'b0, 5'h0C, 32'h0, 4'b1111);
    chk("mt_lo_rd",     {32'd0, bus.o_wb_data}, 64'h0000_0000_FFFF_FFF0);
    mtime = 64'h0000_0006_0000_0000;
    bus_xfer(1'b0, 5'h10, 32'h0, 4'b1111);
    chk("mt_hi_snap",   {32'd0, bus.o_wb_data}, 64'h5);

    // mtime low-half partial write
    mtime = 64'h0000_0001_0000_0000;
    bus_xfer(1'b1, 5'h0C, 32'h1234_5678, 4'b0011);
    chk("mt_wr_en",     {63'd0, mtime_wr_en}, 64'd1);
    chk("mt_wr_din",    mtime_din, 64'h0000_0001_0000_5678);
    chk("mt_wr_nocmp",  {63'd0, cmp_wr_en}, 64'd0);
    chk("mt_wr_ack",    {63'd0, bus.o_wb_ack}, 64'd1);
    @(negedge clk);
    chk("mt_wr_pulse",  {63'd0, mtime_wr_en}, 64'd0);

    // mtime high-half write
    mtime = 64'hAAAA_BBBB_CCCC_DDDD;
    bus_xfer(1'b1, 5'h10, 32'h0000_0077, 4'b1000);
    chk("mt_hi_din",    mtime_din, 64'h00AA_BBBB_CCCC_DDDD);

    // mtimecmp halves
    bus_xfer(1'b1, 5'h04, 32'h0000_0100, 4'b1111);
`ifdef ASRV32_CLINT_ATOMIC_CMP_EN
    chk("cmp_lo_wr",    {63'd0, cmp_wr_en}, 64'd0);
`else
    chk("cmp_lo_wr",    {63'd0, cmp_wr_en}, 64'd1);
    chk("cmp_lo_din",   cmp_din, 64'hFFFF_FFFF_0000_0100);
`endif
    bus_xfer(1'b0, 5'h04, 32'h0, 4'b1111);
    chk("cmp_lo_rd",    {32'd0, bus.o_wb_data}, 64'h100);
    bus_xfer(1'b1, 5'h08, 32'h0, 4'b1111);
    chk("cmp_hi_wr",    {63'd0, cmp_wr_en}, 64'd1);
    chk("cmp_hi_din",   cmp_din, 64'h0000_0000_0000_0100);
    chk("cmp_no_mtwr",  {63'd0, mtime_wr_en}, 64'd0);

    // Unmapped addresses
    bus_xfer(1'b1, 5'h14, 32'hDEAD_BEEF, 4'b1111);
    chk("unm_ack",      {63'd0, bus.o_wb_ack}, 64'd1);
    chk("unm_mtwr",     {63'd0, mtime_wr_en}, 64'd0);
    chk("unm_cmpwr",    {63'd0, cmp_wr_en}, 64'd0);
    bus_xfer(1'b0, 5'h1C, 32'h0, 4'b1111);
    chk("unm_rd",       {32'd0, bus.o_wb_data}, 64'd0);

    // Back-to-back requests held on stb
    @(negedge clk);
    bus.i_wb_cyc  = 1'b1;
    bus.i_wb_stb  = 1'b1;
    bus.i_wb_we   = 1'b0;
    bus.i_wb_addr = 5'h00;
    bus.i_wb_sel  = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("b2b_ack%0d", i),   {63'd0, bus.o_wb_ack},   {63'd0, (i % 2 == 0)});
      chk($sformatf("b2b_stall%0d", i), {63'd0, bus.o_wb_stall}, {63'd0, (i % 2 == 0)});
    end
    bus_idle();

    // Reset during RESP
    @(negedge clk);
    bus.i_wb_cyc  = 1'b1;
    bus.i_wb_stb  = 1'b1;
    bus.i_wb_we   = 1'b1;
    bus.i_wb_addr = 5'h00;
    bus.i_wb_data = 32'h1;
    bus.i_wb_sel  = 4'b0001;
    @(posedge clk);
    #1;
    bus_idle();
    chk("mid_ack",      {63'd0, bus.o_wb_ack}, 64'd1);
    chk("mid_swi",      {63'd0, sw_int}, 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_ack",  {63'd0, bus.o_wb_ack}, 64'd0);
    chk("mid_rst_swi",  {63'd0, sw_int}, 64'd0);
    chk("mid_rst_shadow", cmp_din, 64'hFFFF_FFFF_FFFF_FFFF);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("reinit_cmp_wr", {63'd0, cmp_wr_en}, 64'd1);
    chk("reinit_stall",  {63'd0, bus.o_wb_stall}, 64'd1);
    bus_xfer(1'b0, 5'h00, 32'h0, 4'b1111);
    chk("post_msip",    {32'd0, bus.o_wb_data}, 64'd0);
    bus_xfer(1'b0, 5'h04, 32'h0, 4'b1111);
    chk("post_cmp_lo",  {32'd0, bus.o_wb_data}, 64'hFFFF_FFFF);
    bus_xfer(1'b0, 5'h08, 32'h0, 4'b1111);
    chk("post_cmp_hi",  {32'd0, bus.o_wb_data}, 64'hFFFF_FFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
